// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, FSM states
// and the datapath mux/ALU selector codes.
package control_multiciclo_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

  localparam logic [1:0] ALUB_REGB   = 2'b00;
  localparam logic [1:0] ALUB_CUATRO = 2'b01;
  localparam logic [1:0] ALUB_EXT    = 2'b10;
  localparam logic [1:0] ALUB_DESPL  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic opcode_valido(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_salidas.sv
// Purely combinational decode of the controller state (plus MemListo/opcode
// qualifiers) into every datapath enable and mux select.
module control_multiciclo_salidas
  import control_multiciclo_pkg::*;
(
  input  logic [3:0] estado,
  input  logic       MemListo,
  input  logic [5:0] opcode,
  output logic       EscrPC,
  output logic       EscrPCCond,
  output logic [1:0] FuentePC,
  output logic       IoD,
  output logic       LeerMem,
  output logic       EscrMem,
  output logic       EscrIR,
  output logic       RegDest,
  output logic       MemaReg,
  output logic       EscrReg,
  output logic       FuenteALUA,
  output logic [1:0] FuenteALUB,
  output logic [1:0] ALUOp,
  output logic       Retirada,
  output logic       Excepcion
);

  // Everything defaults low; each state raises only what it needs.
  always_comb begin
    EscrPC     = 1'b0;
    EscrPCCond = 1'b0;
    FuentePC   = PC_ALU;
    IoD        = 1'b0;
    LeerMem    = 1'b0;
    EscrMem    = 1'b0;
    EscrIR     = 1'b0;
    RegDest    = 1'b0;
    MemaReg    = 1'b0;
    EscrReg    = 1'b0;
    FuenteALUA = 1'b0;
    FuenteALUB = ALUB_REGB;
    ALUOp      = ALUOP_ADD;
    Retirada   = 1'b0;
    Excepcion  = 1'b0;
    case (estado)
      FETCH: begin
        LeerMem    = 1'b1;
        FuenteALUB = ALUB_CUATRO;
        EscrIR     = MemListo;
        EscrPC     = MemListo;
      end
      DECODE: begin
        FuenteALUB = ALUB_DESPL;
        Excepcion  = !opcode_valido(opcode);
      end
      MEM_ADDR: begin
        FuenteALUA = 1'b1;
        FuenteALUB = ALUB_EXT;
      end
      MEM_READ: begin
        IoD     = 1'b1;
        LeerMem = 1'b1;
      end
      MEM_WB: begin
        MemaReg  = 1'b1;
        EscrReg  = 1'b1;
        Retirada = 1'b1;
      end
      MEM_WRITE: begin
        IoD      = 1'b1;
        EscrMem  = 1'b1;
        Retirada = MemListo;
      end
      EXEC_R: begin
        FuenteALUA = 1'b1;
        ALUOp      = ALUOP_FUNCT;
      end
      R_WB: begin
        RegDest  = 1'b1;
        EscrReg  = 1'b1;
        Retirada = 1'b1;
      end
      BRANCH: begin
        FuenteALUA = 1'b1;
        ALUOp      = ALUOP_SUB;
        EscrPCCond = 1'b1;
        FuentePC   = PC_ALUOUT;
        Retirada   = 1'b1;
      end
      JUMP: begin
        EscrPC   = 1'b1;
        FuentePC = PC_SALTO;
        Retirada = 1'b1;
      end
      EXEC_I: begin
        FuenteALUA = 1'b1;
        FuenteALUB = ALUB_EXT;
      end
      I_WB: begin
        EscrReg  = 1'b1;
        Retirada = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle Moore controller: sequences fetch/decode/execute/memory/writeback
// over the shared memory, ALU and register bank, stretching memory phases on MemListo.
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       oZero,
  input  logic       MemListo,
  output logic       EscrPC,
  output logic       EscrPCCond,
  output logic [1:0] FuentePC,
  output logic       IoD,
  output logic       LeerMem,
  output logic       EscrMem,
  output logic       EscrIR,
  output logic       RegDest,
  output logic       MemaReg,
  output logic       EscrReg,
  output logic       FuenteALUA,
  output logic [1:0] FuenteALUB,
  output logic [1:0] ALUOp,
  output logic       Retirada,
  output logic       Excepcion,
  output logic [3:0] estado
);

  estado_t estado_q, estado_d;

  logic       d_escr_pc, d_escr_pc_cond, d_iod, d_leer_mem, d_escr_mem, d_escr_ir;
  logic       d_reg_dest, d_mema_reg, d_escr_reg, d_fuente_alua, d_retirada, d_excepcion;
  logic [1:0] d_fuente_pc, d_fuente_alub, d_alu_op;

  // The beq decision is made in the datapath (EscrPCCond & oZero), not here.
  logic unused_ozero;
  assign unused_ozero = oZero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_q <= FETCH;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      FETCH:     if (MemListo) estado_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:         estado_d = EXEC_R;
          OP_LW, OP_SW: estado_d = MEM_ADDR;
          OP_BEQ:       estado_d = BRANCH;
          OP_J:         estado_d = JUMP;
          OP_ADDI:      estado_d = EXEC_I;
          default:      estado_d = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if (opcode == OP_LW)      estado_d = MEM_READ;
        else if (opcode == OP_SW) estado_d = MEM_WRITE;
        else                      estado_d = FETCH;
      end
      MEM_READ:  if (MemListo) estado_d = MEM_WB;
      MEM_WRITE: if (MemListo) estado_d = FETCH;
      EXEC_R:    estado_d = R_WB;
      EXEC_I:    estado_d = I_WB;
      MEM_WB, R_WB, BRANCH, JUMP, I_WB: estado_d = FETCH;
      default:   estado_d = FETCH;
    endcase
  end

  control_multiciclo_salidas u_salidas (
    .estado     (estado_q),
    .MemListo   (MemListo),
    .opcode     (opcode),
    .EscrPC     (d_escr_pc),
    .EscrPCCond (d_escr_pc_cond),
    .FuentePC   (d_fuente_pc),
    .IoD        (d_iod),
    .LeerMem    (d_leer_mem),
    .EscrMem    (d_escr_mem),
    .EscrIR     (d_escr_ir),
    .RegDest    (d_reg_dest),
    .MemaReg    (d_mema_reg),
    .EscrReg    (d_escr_reg),
    .FuenteALUA (d_fuente_alua),
    .FuenteALUB (d_fuente_alub),
    .ALUOp      (d_alu_op),
    .Retirada   (d_retirada),
    .Excepcion  (d_excepcion)
  );

  // Reset gates the decode directly so no strobe survives past the reset edge.
  always_comb begin
    EscrPC     = 1'b0;
    EscrPCCond = 1'b0;
    FuentePC   = 2'b00;
    IoD        = 1'b0;
    LeerMem    = 1'b0;
    EscrMem    = 1'b0;
    EscrIR     = 1'b0;
    RegDest    = 1'b0;
    MemaReg    = 1'b0;
    EscrReg    = 1'b0;
    FuenteALUA = 1'b0;
    FuenteALUB = 2'b00;
    ALUOp      = 2'b00;
    Retirada   = 1'b0;
    Excepcion  = 1'b0;
    estado     = 4'd0;
    if (reset) begin
      EscrPC     = d_escr_pc;
      EscrPCCond = d_escr_pc_cond;
      FuentePC   = d_fuente_pc;
      IoD        = d_iod;
      LeerMem    = d_leer_mem;
      EscrMem    = d_escr_mem;
      EscrIR     = d_escr_ir;
      RegDest    = d_reg_dest;
      MemaReg    = d_mema_reg;
      EscrReg    = d_escr_reg;
      FuenteALUA = d_fuente_alua;
      FuenteALUB = d_fuente_alub;
      ALUOp      = d_alu_op;
      Retirada   = d_retirada;
      Excepcion  = d_excepcion;
      estado     = estado_q;
    end
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control sequencer for the MIPS-subset datapath. It replaces the single-cycle `control` decode with a Moore FSM that sequences one shared memory, one ALU and the register bank over 3–5+ cycles per instruction. It stretches memory phases with a ready handshake. It sits between the instruction register's opcode field and every datapath enable and mux select.

## Interface
Parameters:
- none; opcode and state encodings come from the package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instru[31:26] from the instruction register, valid from DECODE onward
- oZero  in  1  ALU zero flag
- MemListo  in  1  memory ready; completes the current memory access this cycle
- EscrPC  out  1  unconditional PC write
- EscrPCCond  out  1  PC write qualified by oZero (beq)
- FuentePC  out  2  PC source: 00 ALU out, 01 ALUOut reg, 10 jump target
- IoD  out  1  memory address: 0 = PC, 1 = ALUOut reg
- LeerMem  out  1  memory read
- EscrMem  out  1  memory write
- EscrIR  out  1  instruction register load
- RegDest  out  1  write register: 1 = rd, 0 = rt
- MemaReg  out  1  write data: 1 = MDR, 0 = ALUOut reg
- EscrReg  out  1  register bank write
- FuenteALUA  out  1  0 = PC, 1 = reg A
- FuenteALUB  out  2  00 reg B, 01 constant 4, 10 sign-ext, 11 sign-ext<<2
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- Retirada  out  1  one-cycle pulse on the last cycle of each instruction
- Excepcion  out  1  one-cycle pulse on an illegal opcode
- estado  out  4  current state, for debug

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11.
- FETCH: IoD=0, LeerMem=1, FuenteALUA=0, FuenteALUB=01, ALUOp=00, FuentePC=00.
  - EscrIR and EscrPC are asserted only while MemListo=1.
  - Stay in FETCH while MemListo=0; go to DECODE when MemListo=1.
- DECODE: FuenteALUA=0, FuenteALUB=11, ALUOp=00 (branch target into the ALUOut reg). Next state by opcode:
  - R → EXEC_R
  - lw or sw → MEM_ADDR
  - beq → BRANCH
  - j → JUMP
  - addi → EXEC_I
  - any other opcode → FETCH, with Excepcion=1 this cycle and no writes.
- MEM_ADDR: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Next state: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: IoD=1, LeerMem=1. Hold until MemListo=1, then go to MEM_WB.
- MEM_WB: RegDest=0, MemaReg=1, EscrReg=1, Retirada=1. Next state FETCH.
- MEM_WRITE: IoD=1, EscrMem=1. Hold until MemListo=1; in that cycle Retirada=1 and next state is FETCH.
- EXEC_R: FuenteALUA=1, FuenteALUB=00, ALUOp=10. Next state R_WB.
- R_WB: RegDest=1, MemaReg=0, EscrReg=1, Retirada=1. Next state FETCH.
- BRANCH: FuenteALUA=1, FuenteALUB=00, ALUOp=01, EscrPCCond=1, FuentePC=01, Retirada=1. Next state FETCH.
- JUMP: EscrPC=1, FuentePC=10, Retirada=1. Next state FETCH.
- EXEC_I: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Next state I_WB.
- I_WB: RegDest=0, MemaReg=0, EscrReg=1, Retirada=1. Next state FETCH.
- Any output not listed for a state is 0. Unreachable encodings 12–15 go to FETCH with all outputs 0.

## Timing
- Reset low: state becomes FETCH immediately.
  - All outputs are forced to 0 combinationally while reset is low, including LeerMem; estado reads 0.
  - The first fetch request appears in the cycle after reset is released.
- Outputs are Moore, decoded from the state register. Exceptions:
  - EscrIR, EscrPC (in FETCH) and Retirada (in MEM_WRITE) are ANDed with MemListo.
  - Excepcion is decoded from opcode in DECODE.
- Minimum cycles per instruction with MemListo held at 1: R 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Every MemListo=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. All outputs stay stable during a wait.
- MemListo outside the memory states is ignored.
- Reset asserted mid-instruction aborts the instruction; no write strobe is issued after reset falls.

## Structure
- Package `control_multiciclo_pkg` holds:
  - opcode constants
  - state encodings
  - FuentePC, FuenteALUB and ALUOp encodings.
- Sub-module `control_multiciclo_salidas`: a purely combinational decode of (state, MemListo, opcode) to the outputs. The state register and next-state logic stay in the top module.

## Test plan
- Reset released with MemListo=1 and opcode=000000:
  - estado follows 0,1,6,7,0.
  - EscrReg=1 and RegDest=1 only in state 7.
  - Retirada pulses once.
- lw with MemListo low for 2 cycles in FETCH and 3 cycles in MEM_READ:
  - Total of 10 cycles.
  - EscrIR pulses exactly once.
  - LeerMem is held high throughout both waits.
  - MemaReg=1 and EscrReg=1 in state 4.
- sw: EscrMem=1 and IoD=1 in state 5; Retirada pulses only in the cycle MemListo=1; EscrReg stays 0.
- beq:
  - EscrPCCond=1, ALUOp=01 and FuentePC=01 in state 8.
  - Run with oZero=0 and with oZero=1; controller outputs are identical in both runs.
- j, then illegal opcode 111111:
  - j: EscrPC=1 and FuentePC=10 in state 9.
  - Illegal: Excepcion pulses in state 1, next state is 0, no EscrReg or EscrMem.
- Reset dropped during MEM_WRITE with MemListo=0: EscrMem goes to 0 immediately; after release, estado=0 and a fresh fetch begins.
